axi_sram_slave: RTL and testbench

AXI-lite slave memory terminating the AXI side of the memory-to-AXI write/read bridge. Accepts write-address, write-data, read-address and response handshakes from the bridge's `Axi_ift` master, and services them from an internal word-addressed SRAM array with byte-strobe writes and a configurable read latency. Write and read paths are independent state machines, so one write and one read may be in flight at once.

---
 rtl/axi_sram_slave.sv | 242 ++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI-lite slave backed by a word-addressed SRAM with byte-strobe writes and programmable read latency.
// Optional AXI_SRAM_RANGE_CHECK_EN: out-of-range addresses get SLVERR, writes suppressed, reads return 0.
module axi_sram_slave #(
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned MEM_DEPTH    = 4096,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    w_addr_request_valid,
  output logic                    w_addr_request_ready,
  input  logic [ADDR_WIDTH-1:0]   w_addr_request_bits_waddr,
  input  logic                    w_data_request_valid,
  output logic                    w_data_request_ready,
  input  logic [DATA_WIDTH-1:0]   w_data_request_bits_wdata,
  input  logic [DATA_WIDTH/8-1:0] w_data_request_bits_wstrb,
  output logic                    w_reply_valid,
  input  logic                    w_reply_ready,
  output logic [1:0]              w_reply_bits_bresp,
  input  logic                    r_request_valid,
  output logic                    r_request_ready,
  input  logic [ADDR_WIDTH-1:0]   r_request_bits_raddr,
  output logic                    r_reply_valid,
  input  logic                    r_reply_ready,
  output logic [DATA_WIDTH-1:0]   r_reply_bits_rdata,
  output logic [1:0]              r_reply_bits_rresp
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_t              w_state, w_state_n;
  logic                  aw_held, aw_held_n, wd_held, wd_held_n;
  logic [IDX_W-1:0]      aw_idx, aw_idx_n;
  logic                  aw_oor, aw_oor_n;
  logic [DATA_WIDTH-1:0] wd_data, wd_data_n;
  logic [STRB_W-1:0]     wd_strb, wd_strb_n;
  logic                  aw_rdy_n, wd_rdy_n, bvalid_n;
  logic [1:0]            bresp_n;
  logic                  wr_commit, wr_oor;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;

  r_state_t              r_state, r_state_n;
  logic [IDX_W-1:0]      r_idx, r_idx_n, rd_idx;
  logic                  r_oor, r_oor_n, rd_oor, rd_sample;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  ar_rdy_n, rvalid_n;
  logic [1:0]            rresp_n;

  logic                  aw_hs, w_hs, ar_hs, aw_oor_in, ar_oor_in;
  logic [IDX_W-1:0]      aw_idx_in, ar_idx_in;
  logic                  unused_addr;

  assign aw_hs     = w_addr_request_valid & w_addr_request_ready;
  assign w_hs      = w_data_request_valid & w_data_request_ready;
  assign ar_hs     = r_request_valid & r_request_ready;
  assign aw_idx_in = w_addr_request_bits_waddr[OFF +: IDX_W];
  assign ar_idx_in = r_request_bits_raddr[OFF +: IDX_W];
  // Byte-offset bits (and upper bits without range check) are intentionally ignored
  assign unused_addr = ^{w_addr_request_bits_waddr, r_request_bits_raddr};

`ifdef AXI_SRAM_RANGE_CHECK_EN
  assign aw_oor_in = |w_addr_request_bits_waddr[ADDR_WIDTH-1:OFF+IDX_W];
  assign ar_oor_in = |r_request_bits_raddr[ADDR_WIDTH-1:OFF+IDX_W];
`else
  assign aw_oor_in = 1'b0;
  assign ar_oor_in = 1'b0;
`endif

  // Write path: state and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state              <= W_IDLE;
      aw_held              <= 1'b0;
      wd_held              <= 1'b0;
      aw_idx               <= '0;
      aw_oor               <= 1'b0;
      wd_data              <= '0;
      wd_strb              <= '0;
      w_addr_request_ready <= 1'b0;
      w_data_request_ready <= 1'b0;
      w_reply_valid        <= 1'b0;
      w_reply_bits_bresp   <= 2'b00;
    end else begin
      w_state              <= w_state_n;
      aw_held              <= aw_held_n;
      wd_held              <= wd_held_n;
      aw_idx               <= aw_idx_n;
      aw_oor               <= aw_oor_n;
      wd_data              <= wd_data_n;
      wd_strb              <= wd_strb_n;
      w_addr_request_ready <= aw_rdy_n;
      w_data_request_ready <= wd_rdy_n;
      w_reply_valid        <= bvalid_n;
      w_reply_bits_bresp   <= bresp_n;
    end
  end

  // Write path: AW and W latch independently; commit once both are available
  always_comb begin
    w_state_n = w_state;
    aw_held_n = aw_held | aw_hs;
    wd_held_n = wd_held | w_hs;
    aw_idx_n  = aw_hs ? aw_idx_in : aw_idx;
    aw_oor_n  = aw_hs ? aw_oor_in : aw_oor;
    wd_data_n = w_hs ? w_data_request_bits_wdata : wd_data;
    wd_strb_n = w_hs ? w_data_request_bits_wstrb : wd_strb;
    aw_rdy_n  = w_addr_request_ready;
    wd_rdy_n  = w_data_request_ready;
    bvalid_n  = w_reply_valid;
    bresp_n   = w_reply_bits_bresp;
    wr_commit = 1'b0;
    wr_idx    = aw_idx_n;
    wr_oor    = aw_oor_n;
    wr_data   = wd_data_n;
    wr_strb   = wd_strb_n;
    case (w_state)
      W_IDLE: begin
        aw_rdy_n = ~aw_held_n;
        wd_rdy_n = ~wd_held_n;
        if (aw_held_n && wd_held_n) begin
          wr_commit = 1'b1;
          w_state_n = W_RESP;
          aw_rdy_n  = 1'b0;
          wd_rdy_n  = 1'b0;
          bvalid_n  = 1'b1;
          bresp_n   = wr_oor ? 2'b10 : 2'b00;
        end
      end
      W_RESP: begin
        if (w_reply_ready) begin
          w_state_n = W_IDLE;
          aw_held_n = 1'b0;
          wd_held_n = 1'b0;
          aw_rdy_n  = 1'b1;
          wd_rdy_n  = 1'b1;
          bvalid_n  = 1'b0;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // Read path: state and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state            <= R_IDLE;
      r_idx              <= '0;
      r_oor              <= 1'b0;
      cnt                <= '0;
      r_request_ready    <= 1'b0;
      r_reply_valid      <= 1'b0;
      r_reply_bits_rresp <= 2'b00;
    end else begin
      r_state            <= r_state_n;
      r_idx              <= r_idx_n;
      r_oor              <= r_oor_n;
      cnt                <= cnt_n;
      r_request_ready    <= ar_rdy_n;
      r_reply_valid      <= rvalid_n;
      r_reply_bits_rresp <= rresp_n;
    end
  end

  // Read path: latency countdown, array sampled on the edge entering R_RESP
  always_comb begin
    r_state_n = r_state;
    r_idx_n   = r_idx;
    r_oor_n   = r_oor;
    cnt_n     = cnt;
    ar_rdy_n  = r_request_ready;
    rvalid_n  = r_reply_valid;
    rresp_n   = r_reply_bits_rresp;
    rd_sample = 1'b0;
    rd_idx    = r_idx;
    rd_oor    = r_oor;
    case (r_state)
      R_IDLE: begin
        ar_rdy_n = 1'b1;
        if (ar_hs) begin
          ar_rdy_n = 1'b0;
          r_idx_n  = ar_idx_in;
          r_oor_n  = ar_oor_in;
          cnt_n    = CNT_W'(READ_LATENCY);
          if (READ_LATENCY == 0) begin
            rd_sample = 1'b1;
            rd_idx    = ar_idx_in;
            rd_oor    = ar_oor_in;
            r_state_n = R_RESP;
            rvalid_n  = 1'b1;
            rresp_n   = ar_oor_in ? 2'b10 : 2'b00;
          end else begin
            r_state_n = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          rd_sample = 1'b1;
          r_state_n = R_RESP;
          rvalid_n  = 1'b1;
          rresp_n   = r_oor ? 2'b10 : 2'b00;
        end
      end
      R_RESP: begin
        if (r_reply_ready) begin
          r_state_n = R_IDLE;
          rvalid_n  = 1'b0;
          ar_rdy_n  = 1'b1;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  // SRAM write port; contents are not reset
  always_ff @(posedge clk) begin
    if (rstn && wr_commit && !wr_oor) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Read data register; a same-edge write is not yet visible here
  always_ff @(posedge clk) begin
    if (!rstn) r_reply_bits_rdata <= '0;
    else if (rd_sample) r_reply_bits_rdata <= rd_oor ? '0 : mem[rd_idx];
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave (default parameters, READ_LATENCY = 2).
module tb_axi_sram_slave;
  logic        clk = 1'b0;
  logic        rstn;
  logic        awv, awr, wv, wr, bv, br, arv, arr, rv, rr;
  logic [63:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int tests = 0;
  int fails = 0;

  axi_sram_slave dut (
    .clk(clk), .rstn(rstn),
    .w_addr_request_valid(awv), .w_addr_request_ready(awr), .w_addr_request_bits_waddr(awaddr),
    .w_data_request_valid(wv), .w_data_request_ready(wr),
    .w_data_request_bits_wdata(wdata), .w_data_request_bits_wstrb(wstrb),
    .w_reply_valid(bv), .w_reply_ready(br), .w_reply_bits_bresp(bresp),
    .r_request_valid(arv), .r_request_ready(arr), .r_request_bits_raddr(araddr),
    .r_reply_valid(rv), .r_reply_ready(rr), .r_reply_bits_rdata(rdata), .r_reply_bits_rresp(rresp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // AW and W together, then accept B; reports B state and readiness afterwards
  task automatic wr_word(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                         output logic got_bv, output logic [1:0] got_br, output logic rdy_after);
    awv = 1'b1; awaddr = a; wv = 1'b1; wdata = d; wstrb = s;
    cyc();
    awv = 1'b0; wv = 1'b0;
    got_bv = bv; got_br = bresp;
    br = 1'b1;
    cyc();
    br = 1'b0;
    rdy_after = awr & wr;
  endtask

  // AR, wait (bounded) for R, accept it; lat counts cycles from AR handshake to rvalid
  task automatic rd_word(input logic [63:0] a, output logic [63:0] d, output logic [1:0] rs,
                         output int lat);
    arv = 1'b1; araddr = a;
    cyc();
    arv = 1'b0;
    lat = 1;
    while (!rv && lat < 20) begin cyc(); lat++; end
    d = rdata; rs = rresp;
    rr = 1'b1;
    cyc();
    rr = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) cyc();
    tests++;
    if ({awr, wr, arr, bv, rv} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 00000", {awr, wr, arr, bv, rv});
    end
    tests++;
    if ({rdata, bresp, rresp} !== 68'h0) begin
      fails++; $display("FAIL reset_payload: rdata %h bresp %b rresp %b want zeros", rdata, bresp, rresp);
    end
    rstn = 1'b1;
    cyc();
    tests++;
    if ({awr, wr, arr} !== 3'b111) begin
      fails++; $display("FAIL reset_release_ready: got %b want 111", {awr, wr, arr});
    end
  endtask

  task automatic test_basic();
    logic gbv, rdy; logic [1:0] gbr, rs; logic [63:0] d; int lat;
    awv = 1'b1; awaddr = 64'h10; wv = 1'b1; wdata = 64'h1122334455667788; wstrb = 8'hFF;
    cyc();
    awv = 1'b0; wv = 1'b0;
    tests++;
    if ({bv, bresp, awr, wr} !== 5'b1_00_00) begin
      fails++; $display("FAIL basic_b: bv/bresp/awr/wr got %b want 10000", {bv, bresp, awr, wr});
    end
    br = 1'b1; cyc(); br = 1'b0;
    tests++;
    if ({bv, awr, wr} !== 3'b011) begin
      fails++; $display("FAIL basic_b2b: bv/awr/wr got %b want 011", {bv, awr, wr});
    end
    rd_word(64'h10, d, rs, lat);
    tests++;
    if (d !== 64'h1122334455667788 || rs !== 2'b00) begin
      fails++; $display("FAIL basic_read: got %h/%b want 1122334455667788/00", d, rs);
    end
    tests++;
    if (lat !== 3) begin
      fails++; $display("FAIL basic_latency: got %0d want 3", lat);
    end
    tests++;
    if (arr !== 1'b1) begin
      fails++; $display("FAIL basic_ar_b2b: got %b want 1", arr);
    end
    wr_word(64'h18, 64'hCAFE, 8'hFF, gbv, gbr, rdy);
  endtask

  task automatic test_strobe();
    logic gbv, rdy; logic [1:0] gbr, rs; logic [63:0] d; int lat;
    wr_word(64'h20, 64'hFFFFFFFFFFFFFFFF, 8'hFF, gbv, gbr, rdy);
    wv = 1'b1; wdata = 64'h0; wstrb = 8'h0F;
    cyc();
    wv = 1'b0;
    tests++;
    if ({wr, awr, bv} !== 3'b010) begin
      fails++; $display("FAIL strobe_w_only: wr/awr/bv got %b want 010", {wr, awr, bv});
    end
    cyc(); cyc();
    tests++;
    if (bv !== 1'b0) begin
      fails++; $display("FAIL strobe_no_early_b: got %b want 0", bv);
    end
    awv = 1'b1; awaddr = 64'h20;
    cyc();
    awv = 1'b0;
    tests++;
    if (bv !== 1'b1 || bresp !== 2'b00) begin
      fails++; $display("FAIL strobe_b: bv %b bresp %b want 1/00", bv, bresp);
    end
    br = 1'b1; cyc(); br = 1'b0;
    rd_word(64'h20, d, rs, lat);
    tests++;
    if (d !== 64'hFFFFFFFF00000000) begin
      fails++; $display("FAIL strobe_read: got %h want ffffffff00000000", d);
    end
  endtask

  task automatic test_stall();
    logic [63:0] d0;
    arv = 1'b1; araddr = 64'h18;
    cyc();
    arv = 1'b0;
    cyc(); cyc();
    d0 = 64'hCAFE;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (rv !== 1'b1 || rdata !== d0 || arr !== 1'b0) begin
        fails++; $display("FAIL stall_hold[%0d]: rv %b rdata %h arr %b want 1/%h/0", i, rv, rdata, arr, d0);
      end
      cyc();
    end
    rr = 1'b1; cyc(); rr = 1'b0;
    tests++;
    if (rv !== 1'b0 || arr !== 1'b1) begin
      fails++; $display("FAIL stall_release: rv %b arr %b want 0/1", rv, arr);
    end
  endtask

  task automatic test_collision();
    logic gbv, rdy; logic [1:0] gbr, rs; logic [63:0] d; int lat;
    wr_word(64'h30, 64'hAA, 8'hFF, gbv, gbr, rdy);
    arv = 1'b1; araddr = 64'h30;
    cyc();
    arv = 1'b0;
    cyc();
    awv = 1'b1; awaddr = 64'h30; wv = 1'b1; wdata = 64'hBB; wstrb = 8'hFF;
    cyc();
    awv = 1'b0; wv = 1'b0;
    tests++;
    if (rv !== 1'b1 || bv !== 1'b1 || rdata !== 64'hAA) begin
      fails++; $display("FAIL collision_old: rv %b bv %b rdata %h want 1/1/aa", rv, bv, rdata);
    end
    br = 1'b1; rr = 1'b1; cyc(); br = 1'b0; rr = 1'b0;
    rd_word(64'h30, d, rs, lat);
    tests++;
    if (d !== 64'hBB) begin
      fails++; $display("FAIL collision_new: got %h want bb", d);
    end
  endtask

  task automatic test_range();
    logic gbv, rdy; logic [1:0] gbr, rs, rs0; logic [63:0] d, d0; int lat;
    wr_word(64'h0, 64'h5555, 8'hFF, gbv, gbr, rdy);
    wr_word(64'h8000, 64'hDEAD, 8'hFF, gbv, gbr, rdy);
    rd_word(64'h8000, d, rs, lat);
    rd_word(64'h0, d0, rs0, lat);
`ifdef AXI_SRAM_RANGE_CHECK_EN
    tests++;
    if (gbv !== 1'b1 || gbr !== 2'b10 || rs !== 2'b10 || d !== 64'h0) begin
      fails++; $display("FAIL range_resp: bv %b bresp %b rresp %b rdata %h want 1/10/10/0", gbv, gbr, rs, d);
    end
    tests++;
    if (d0 !== 64'h5555 || rs0 !== 2'b00) begin
      fails++; $display("FAIL range_word0: got %h/%b want 5555/00", d0, rs0);
    end
`else
    tests++;
    if (gbv !== 1'b1 || gbr !== 2'b00 || rs !== 2'b00 || d !== 64'hDEAD) begin
      fails++; $display("FAIL range_wrap_resp: bv %b bresp %b rresp %b rdata %h want 1/00/00/dead", gbv, gbr, rs, d);
    end
    tests++;
    if (d0 !== 64'hDEAD || rs0 !== 2'b00) begin
      fails++; $display("FAIL range_word0: got %h/%b want dead/00", d0, rs0);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [1:0] rs; logic [63:0] d; int lat;
    awv = 1'b1; awaddr = 64'h40; wv = 1'b1; wdata = 64'h1234; wstrb = 8'hFF;
    arv = 1'b1; araddr = 64'h10;
    cyc();
    awv = 1'b0; wv = 1'b0; arv = 1'b0;
    rstn = 1'b0;
    cyc();
    tests++;
    if ({bv, rv, awr, wr, arr} !== 5'b0 || rdata !== 64'h0) begin
      fails++; $display("FAIL midreset_clear: bv/rv/rdy %b rdata %h want 00000/0", {bv, rv, awr, wr, arr}, rdata);
    end
    rstn = 1'b1;
    cyc();
    tests++;
    if ({awr, wr, arr} !== 3'b111) begin
      fails++; $display("FAIL midreset_ready: got %b want 111", {awr, wr, arr});
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (bv !== 1'b0 || rv !== 1'b0) begin
        fails++; $display("FAIL midreset_stale[%0d]: bv %b rv %b want 0/0", i, bv, rv);
      end
      cyc();
    end
    rd_word(64'h40, d, rs, lat);
    tests++;
    if (d !== 64'h1234) begin
      fails++; $display("FAIL midreset_persist: got %h want 1234", d);
    end
  endtask

  initial begin
    rstn = 1'b0; awv = 1'b0; wv = 1'b0; br = 1'b0; arv = 1'b0; rr = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    test_reset();
    test_basic();
    test_strobe();
    test_stall();
    test_collision();
    test_range();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
